wf_issue_arb_40: RTL and testbench

WF_ISSUE_ARB_40 -- requirements
Module: wf_issue_arb_40

---
 rtl/wf_issue_arb_40.sv | 148 ++++++++++++++
 tb/tb_wf_issue_arb_40.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/wf_issue_arb_40.sv
// wf_issue_arb_40: round-robin issue arbiter over 40 wavefront slots.
// Registered grant (1-cycle latency), sticky until out_valid&out_ready,
// synchronous flush, back-to-back rearbitration on handshake.
// Optional macro WF_ARB_BURST_EN: up to BURST_LEN consecutive grants
// to the same slot before rotating.
module wf_issue_arb_40 #(
    parameter int unsigned BURST_LEN = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [39:0] req,
    input  logic        flush,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [5:0]  out_select,
    output logic [39:0] grant_onehot
);

    localparam int unsigned NSLOT = 40;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t      state, state_nxt;
    logic [5:0]  sel, sel_nxt;
    logic [5:0]  last_ptr, last_ptr_nxt;
    logic [5:0]  arb_base;
    logic [5:0]  arb_pick;
    logic        arb_found;
    logic        handshake;

`ifdef WF_ARB_BURST_EN
    localparam int unsigned CW = (BURST_LEN > 1) ? $clog2(BURST_LEN + 1) : 1;
    logic [CW-1:0] burst, burst_nxt;
    logic          burst_again;
`else
    logic unused_burst_len;
    assign unused_burst_len = ^32'(BURST_LEN);
`endif

    // Search starts one past the last accepted slot when idle, one past the
    // current grant when rearbitrating on a handshake.
    assign arb_base  = (state == GRANT) ? sel : last_ptr;
    assign handshake = (state == GRANT) && out_ready && !flush;

    // Rotating first-set-bit search: arb_base+1 upward, wrapping 39->0,
    // ending at arb_base inclusive.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        arb_pick  = '0;
        arb_found = 1'b0;
        for (int unsigned k = 0; k < NSLOT; k++) begin
            idx = 32'(arb_base) + 32'd1 + k;
            if (idx >= NSLOT) idx = idx - NSLOT;
            if (!arb_found && req[6'(idx)]) begin
                arb_found = 1'b1;
                arb_pick  = 6'(idx);
            end
        end
    end

`ifdef WF_ARB_BURST_EN
    assign burst_again = req[sel] && (burst < CW'(BURST_LEN - 1));
`endif

    // Next-state, next-select and pointer update; flush wins over handshake.
    always_comb begin
        state_nxt    = state;
        sel_nxt      = sel;
        last_ptr_nxt = last_ptr;
`ifdef WF_ARB_BURST_EN
        burst_nxt    = burst;
`endif
        if (flush) begin
            state_nxt = IDLE;
`ifdef WF_ARB_BURST_EN
            burst_nxt = '0;
`endif
        end else begin
            case (state)
                IDLE: begin
`ifdef WF_ARB_BURST_EN
                    burst_nxt = '0;
`endif
                    if (arb_found) begin
                        state_nxt = GRANT;
                        sel_nxt   = arb_pick;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        last_ptr_nxt = sel;
`ifdef WF_ARB_BURST_EN
                        if (burst_again) begin
                            burst_nxt = burst + CW'(1);
                        end else if (arb_found) begin
                            sel_nxt   = arb_pick;
                            burst_nxt = '0;
                        end else begin
                            state_nxt = IDLE;
                            burst_nxt = '0;
                        end
`else
                        if (arb_found) begin
                            sel_nxt = arb_pick;
                        end else begin
                            state_nxt = IDLE;
                        end
`endif
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State, grant and pointer registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sel      <= '0;
            last_ptr <= 6'd39;
        end else begin
            state    <= state_nxt;
            sel      <= sel_nxt;
            last_ptr <= last_ptr_nxt;
        end
    end

`ifdef WF_ARB_BURST_EN
    // Consecutive-grant counter for the current slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst <= '0;
        end else begin
            burst <= burst_nxt;
        end
    end
`endif

    assign out_valid    = (state == GRANT);
    assign out_select   = sel;
    assign grant_onehot = out_valid ? (40'h1 << sel) : '0;

endmodule

// File: tb/tb_wf_issue_arb_40.sv
// Directed, table-driven bench for wf_issue_arb_40 plus hand-written
// sequences for rotation/burst and asynchronous reset mid-grant.
module tb_wf_issue_arb_40;

    logic        clk;
    logic        rst_n;
    logic [39:0] req;
    logic        flush;
    logic        out_ready;
    logic        out_valid;
    logic [5:0]  out_select;
    logic [39:0] grant_onehot;

    int checks = 0;
    int errors = 0;

    wf_issue_arb_40 #(.BURST_LEN(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .flush        (flush),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .out_select   (out_select),
        .grant_onehot (grant_onehot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [39:0] req;
        logic        flush;
        logic        rdy;
        logic        ev;
        logic [5:0]  es;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic check_outputs(input string nm, input logic ev, input logic [5:0] es);
        logic [39:0] oh;
        oh = ev ? (40'h1 << es) : 40'h0;
        check({nm, ".valid"}, 64'(out_valid), 64'(ev));
        if (ev) check({nm, ".select"}, 64'(out_select), 64'(es));
        check({nm, ".onehot"}, 64'(grant_onehot), 64'(oh));
    endtask

    initial begin
        // req, flush, rdy, expected valid, expected select
        vecs[0]  = '{40'h1,                       1'b0, 1'b0, 1'b1, 6'd0};
        vecs[1]  = '{40'h1,                       1'b0, 1'b1, 1'b1, 6'd0};
        vecs[2]  = '{40'h0,                       1'b0, 1'b1, 1'b0, 6'd0};
        vecs[3]  = '{40'h1 << 5,                  1'b0, 1'b0, 1'b1, 6'd5};
        vecs[4]  = '{40'h0,                       1'b0, 1'b0, 1'b1, 6'd5};
        vecs[5]  = '{40'h0,                       1'b0, 1'b0, 1'b1, 6'd5};
        vecs[6]  = '{40'h0,                       1'b0, 1'b0, 1'b1, 6'd5};
        vecs[7]  = '{40'h0,                       1'b0, 1'b0, 1'b1, 6'd5};
        vecs[8]  = '{40'h0,                       1'b0, 1'b1, 1'b0, 6'd5};
        vecs[9]  = '{40'h1 << 10,                 1'b0, 1'b0, 1'b1, 6'd10};
        vecs[10] = '{(40'h1 << 10) | (40'h1 << 20), 1'b1, 1'b1, 1'b0, 6'd10};
        vecs[11] = '{(40'h1 << 10) | (40'h1 << 20), 1'b0, 1'b0, 1'b1, 6'd10};
        vecs[12] = '{40'h0,                       1'b1, 1'b0, 1'b0, 6'd10};
        vecs[13] = '{(40'h1 << 39) | 40'h1,       1'b0, 1'b0, 1'b1, 6'd39};
        vecs[14] = '{40'h1,                       1'b0, 1'b1, 1'b1, 6'd0};
        vecs[15] = '{40'h0,                       1'b0, 1'b1, 1'b0, 6'd0};

        rst_n     = 1'b0;
        req       = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        #1;
        check("reset.valid",    64'(out_valid),    64'd0);
        check("reset.select",   64'(out_select),   64'd0);
        check("reset.onehot",   64'(grant_onehot), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req       = vecs[i].req;
            flush     = vecs[i].flush;
            out_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].es);
        end

        // Rotation (or burst) with out_ready held high, starting from IDLE, last_ptr=0.
        begin
`ifdef WF_ARB_BURST_EN
            logic [5:0] seq[9];
            seq = '{6'd2, 6'd2, 6'd2, 6'd2, 6'd7, 6'd7, 6'd7, 6'd7, 6'd2};
            @(negedge clk);
            req = (40'h1 << 2) | (40'h1 << 7);
`else
            logic [5:0] seq[5];
            seq = '{6'd3, 6'd17, 6'd39, 6'd3, 6'd17};
            @(negedge clk);
            req = (40'h1 << 3) | (40'h1 << 17) | (40'h1 << 39);
`endif
            flush     = 1'b0;
            out_ready = 1'b1;
            foreach (seq[j]) begin
                @(posedge clk);
                #1;
                check_outputs($sformatf("seq%0d", j), 1'b1, seq[j]);
            end
        end

        // Asynchronous reset asserted between edges while a grant is pending.
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        check("pre_rst.valid", 64'(out_valid), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst.valid",  64'(out_valid),    64'd0);
        check("async_rst.select", 64'(out_select),   64'd0);
        check("async_rst.onehot", 64'(grant_onehot), 64'd0);

        // First grant after reset searches from slot 0.
        @(negedge clk);
        rst_n = 1'b1;
        req   = (40'h1 << 5) | 40'h1;
        @(posedge clk);
        #1;
        check_outputs("post_rst", 1'b1, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
